haar_cascade_sequencer: RTL and testbench

HAAR_CASCADE_SEQUENCER -- requirements
Module: haar_cascade_sequencer

---
 rtl/haar_pkg.sv | 29 ++
 rtl/haar_cascade_sequencer.sv | 111 +++++++++++
 tb/tb_haar_cascade_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/haar_pkg.sv
// Shared types and stage ROM field layout for the Haar cascade sequencer.
`timescale 1ns/1ps
package haar_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_RUN,
    ST_DRAIN,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam int unsigned STAGE_WORD_W = 24;
  localparam int unsigned CLF_N_LSB    = 16;
  localparam int unsigned CLF_N_W      = 8;
  localparam int unsigned THRESH_LSB   = 0;
  localparam int unsigned THRESH_W     = 16;

  function automatic logic [CLF_N_W-1:0] stage_clf_count(input logic [STAGE_WORD_W-1:0] word);
    return word[CLF_N_LSB +: CLF_N_W];
  endfunction

  function automatic logic [THRESH_W-1:0] stage_thresh(input logic [STAGE_WORD_W-1:0] word);
    return word[THRESH_LSB +: THRESH_W];
  endfunction

endpackage

// File: rtl/haar_cascade_sequencer.sv
// Walks the stage table for one detection window, streaming classifier addresses
// to the evaluator and stopping at the first stage whose sum misses its threshold.
`timescale 1ns/1ps
module haar_cascade_sequencer
  import haar_pkg::*;
#(
  parameter int unsigned NUM_STAGES   = 22,
  parameter int unsigned CLF_ADDR_W   = 12,
  parameter int unsigned STAGE_ADDR_W = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      detected,
  output logic [STAGE_ADDR_W-1:0]   fail_stage,
  output logic [STAGE_ADDR_W-1:0]   stage_rom_addr,
  input  logic [STAGE_WORD_W-1:0]   stage_rom_data,
  output logic [CLF_ADDR_W-1:0]     clf_rom_addr,
  output logic                      clf_rst,
  output logic                      clf_en,
  output logic [THRESH_W-1:0]       stage_threshold,
  input  logic                      stage_status
);

  localparam logic [STAGE_ADDR_W-1:0] LAST_STAGE = STAGE_ADDR_W'(NUM_STAGES - 1);
  localparam logic [STAGE_ADDR_W-1:0] ALL_PASSED = STAGE_ADDR_W'(NUM_STAGES);

  state_t             state;
  logic [CLF_N_W-1:0] clf_left;

  // stage_rom_addr doubles as the current stage index for the whole window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      detected        <= 1'b0;
      fail_stage      <= '0;
      stage_rom_addr  <= '0;
      clf_rom_addr    <= '0;
      clf_rst         <= 1'b0;
      clf_en          <= 1'b0;
      stage_threshold <= '0;
      clf_left        <= '0;
    end else begin
      done    <= 1'b0;
      clf_rst <= 1'b0;
      // Evaluator sees ROM data one cycle after each address issued in RUN.
      clf_en  <= (state == ST_RUN);
      case (state)
        ST_IDLE: begin
          if (start) begin
            state          <= ST_LOAD;
            busy           <= 1'b1;
            stage_rom_addr <= '0;
            clf_rom_addr   <= '0;
            detected       <= 1'b0;
            fail_stage     <= '0;
          end
        end
        ST_LOAD: begin
          state   <= ST_WAIT;
          clf_rst <= 1'b1;
        end
        ST_WAIT: begin
          stage_threshold <= stage_thresh(stage_rom_data);
          clf_left        <= stage_clf_count(stage_rom_data);
          state           <= (stage_clf_count(stage_rom_data) != '0) ? ST_RUN : ST_DRAIN;
        end
        ST_RUN: begin
          // Flat classifier table: the address keeps counting across stages.
          clf_rom_addr <= clf_rom_addr + 1'b1;
          clf_left     <= clf_left - 1'b1;
          if (clf_left == CLF_N_W'(1)) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (!stage_status) begin
            state      <= ST_DONE;
            done       <= 1'b1;
            detected   <= 1'b0;
            fail_stage <= stage_rom_addr;
          end else if (stage_rom_addr == LAST_STAGE) begin
            state      <= ST_DONE;
            done       <= 1'b1;
            detected   <= 1'b1;
            fail_stage <= ALL_PASSED;
          end else begin
            state          <= ST_LOAD;
            stage_rom_addr <= stage_rom_addr + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_haar_cascade_sequencer.sv
// Bench for haar_cascade_sequencer: two parameterisations, ROM and evaluator models,
// directed table vectors plus random windows against a window-level reference.
`timescale 1ns/1ps
module tb_haar_cascade_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic sel;
  logic start_a, start_b;
  logic stage_status;
  logic [23:0] stage_rom_q;
  logic [7:0]  clf_q;
  logic [15:0] acc;

  logic a_busy, a_done, a_det, a_crst, a_cen;
  logic [4:0]  a_fail, a_sra;
  logic [11:0] a_cra;
  logic [15:0] a_thr;
  logic b_busy, b_done, b_det, b_crst, b_cen;
  logic [4:0]  b_fail, b_sra;
  logic [2:0]  b_cra;
  logic [15:0] b_thr;

  logic m_busy, m_done, m_det, m_crst, m_cen;
  logic [4:0]  m_fail, m_sra;
  logic [11:0] m_cra;
  logic [15:0] m_thr;

  logic [7:0]  st_n   [0:31];
  logic [15:0] st_thr [0:31];
  logic [7:0]  clf_w  [0:4095];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  haar_cascade_sequencer #(.NUM_STAGES(2), .CLF_ADDR_W(12), .STAGE_ADDR_W(5)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(a_busy), .done(a_done),
    .detected(a_det), .fail_stage(a_fail), .stage_rom_addr(a_sra),
    .stage_rom_data(stage_rom_q), .clf_rom_addr(a_cra), .clf_rst(a_crst),
    .clf_en(a_cen), .stage_threshold(a_thr), .stage_status(stage_status));

  haar_cascade_sequencer #(.NUM_STAGES(3), .CLF_ADDR_W(3), .STAGE_ADDR_W(5)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(b_busy), .done(b_done),
    .detected(b_det), .fail_stage(b_fail), .stage_rom_addr(b_sra),
    .stage_rom_data(stage_rom_q), .clf_rom_addr(b_cra), .clf_rst(b_crst),
    .clf_en(b_cen), .stage_threshold(b_thr), .stage_status(stage_status));

  assign m_busy = sel ? b_busy : a_busy;
  assign m_done = sel ? b_done : a_done;
  assign m_det  = sel ? b_det  : a_det;
  assign m_fail = sel ? b_fail : a_fail;
  assign m_sra  = sel ? b_sra  : a_sra;
  assign m_cra  = sel ? {9'd0, b_cra} : a_cra;
  assign m_crst = sel ? b_crst : a_crst;
  assign m_cen  = sel ? b_cen  : a_cen;
  assign m_thr  = sel ? b_thr  : a_thr;

  // ROMs with one cycle read latency, and an accumulating evaluator.
  always @(posedge clk) begin
    stage_rom_q <= {st_n[m_sra], st_thr[m_sra]};
    clf_q       <= clf_w[m_cra];
  end

  always @(posedge clk or posedge rst) begin
    if (rst) acc <= '0;
    else if (m_crst) acc <= '0;
    else if (m_cen) acc <= acc + 16'(clf_q);
  end

  assign stage_status = (acc > m_thr);

  typedef struct {
    logic s;
    int   rep;
    int   n0, n1, n2;
    int   t0, t1, t2;
    int   det, fail, cyc, en;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Window-level reference: sums weights over the flat classifier table per stage.
  task automatic ref_model(input int ns, input int aw, output int det, output int fail,
                           output int cyc, output int en, output int nrst);
    int a, sum;
    a = 0; cyc = 1; en = 0; nrst = 0; det = 1; fail = ns;
    for (int s = 0; s < ns; s++) begin
      sum = 0;
      for (int j = 0; j < int'(st_n[s]); j++) begin
        sum += int'(clf_w[a % (1 << aw)]);
        a++;
      end
      en += int'(st_n[s]);
      nrst++;
      cyc += int'(st_n[s]) + 4;
      if (!(sum > int'(st_thr[s]))) begin
        det = 0;
        fail = s;
        break;
      end
    end
  endtask

  task automatic run_window(input logic s, input int repulse, output int det, output int fail,
                            output int cyc, output int en, output int nrst, output int maxst,
                            output int errs);
    int exp_addr, prev_addr, aw, k;
    bit seen;
    aw = s ? 3 : 12;
    det = -1; fail = -1; en = 0; nrst = 0; maxst = 0; errs = 0; exp_addr = 0; seen = 0; k = 0;
    @(negedge clk);
    sel = s;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    prev_addr = 0;
    while (!seen && k < 300) begin
      k++;
      if (k > 1) begin
        @(posedge clk); #1;
      end
      start = (repulse != 0 && k >= 3 && k <= 8) ? 1'b1 : 1'b0;
      if (k == 1 && (m_det !== 1'b0 || m_fail !== 5'd0)) errs++;
      if (m_busy !== 1'b1) errs++;
      if (m_cen) begin
        if (prev_addr != (exp_addr % (1 << aw))) errs++;
        if (m_thr != st_thr[m_sra]) errs++;
        exp_addr++;
        en++;
      end
      if (m_crst) nrst++;
      if (int'(m_sra) > maxst) maxst = int'(m_sra);
      if (m_done) begin
        seen = 1;
        det = int'(m_det);
        fail = int'(m_fail);
      end
      prev_addr = int'(m_cra);
    end
    start = 1'b0;
    cyc = seen ? k : -1;
    @(posedge clk); #1;
    if (m_done !== 1'b0 || m_busy !== 1'b0) errs++;
  endtask

  task automatic load_stages(input int n0, n1, n2, t0, t1, t2);
    st_n[0] = 8'(n0); st_n[1] = 8'(n1); st_n[2] = 8'(n2);
    st_thr[0] = 16'(t0); st_thr[1] = 16'(t1); st_thr[2] = 16'(t2);
  endtask

  vec_t vecs [6];

  initial begin
    int det, fail, cyc, en, nrst, maxst, errs;
    int e_det, e_fail, e_cyc, e_en, e_nrst, ns, dcount;

    vecs[0] = '{1'b0, 0, 2, 3, 0, 0, 0, 0, 1, 2, 14, 5};
    vecs[1] = '{1'b1, 0, 1, 2, 4, 0, 5, 0, 0, 1, 12, 3};
    vecs[2] = '{1'b1, 0, 3, 4, 3, 2, 3, 2, 1, 3, 23, 10};
    vecs[3] = '{1'b0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 5, 0};
    vecs[4] = '{1'b0, 0, 1, 1, 0, 0, 1, 0, 0, 1, 11, 2};
    vecs[5] = '{1'b1, 1, 4, 2, 1, 0, 0, 0, 1, 3, 20, 7};

    for (int i = 0; i < 32; i++) begin
      st_n[i] = '0;
      st_thr[i] = '0;
    end
    for (int i = 0; i < 4096; i++) clf_w[i] = 8'd1;

    rst = 1'b1; start = 1'b0; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_a_outputs", int'(|{a_busy, a_done, a_det, a_fail, a_sra, a_cra, a_crst, a_cen, a_thr}), 0);
    check("reset_b_outputs", int'(|{b_busy, b_done, b_det, b_fail, b_sra, b_cra, b_crst, b_cen, b_thr}), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Directed table vectors with unit classifier weights.
    for (int v = 0; v < 6; v++) begin
      load_stages(vecs[v].n0, vecs[v].n1, vecs[v].n2, vecs[v].t0, vecs[v].t1, vecs[v].t2);
      run_window(vecs[v].s, vecs[v].rep, det, fail, cyc, en, nrst, maxst, errs);
      ns = vecs[v].s ? 3 : 2;
      e_nrst = vecs[v].det ? ns : vecs[v].fail + 1;
      check($sformatf("vec%0d_detected", v), det, vecs[v].det);
      check($sformatf("vec%0d_fail_stage", v), fail, vecs[v].fail);
      check($sformatf("vec%0d_done_cycle", v), cyc, vecs[v].cyc);
      check($sformatf("vec%0d_clf_en_count", v), en, vecs[v].en);
      check($sformatf("vec%0d_clf_rst_count", v), nrst, e_nrst);
      check($sformatf("vec%0d_max_stage_addr", v), maxst, e_nrst - 1);
      check($sformatf("vec%0d_trace_errors", v), errs, 0);
    end

    // Reset in the middle of stage 1 RUN, then a clean restart.
    load_stages(1, 3, 0, 0, 0, 0);
    @(negedge clk);
    sel = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("midrst_pre_stage", int'(m_sra), 1);
    check("midrst_pre_clf_en", int'(m_cen), 1);
    rst = 1'b1;
    #1;
    check("midrst_outputs_zero", int'(|{a_busy, a_done, a_det, a_fail, a_sra, a_cra, a_crst, a_cen, a_thr}), 0);
    #2;
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (a_done || a_busy) dcount++;
    end
    check("midrst_no_done", dcount, 0);
    run_window(1'b0, 0, det, fail, cyc, en, nrst, maxst, errs);
    check("restart_detected", det, 1);
    check("restart_fail_stage", fail, 2);
    check("restart_done_cycle", cyc, 13);
    check("restart_trace_errors", errs, 0);

    // Random windows with random weights and thresholds.
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < 64; i++) clf_w[i] = 8'($urandom_range(0, 3));
      load_stages($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                  $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
      ns = (r % 2 == 1) ? 3 : 2;
      ref_model(ns, (r % 2 == 1) ? 3 : 12, e_det, e_fail, e_cyc, e_en, e_nrst);
      run_window((r % 2 == 1) ? 1'b1 : 1'b0, r % 3 == 0 ? 1 : 0, det, fail, cyc, en, nrst, maxst, errs);
      check($sformatf("rnd%0d_detected", r), det, e_det);
      check($sformatf("rnd%0d_fail_stage", r), fail, e_fail);
      check($sformatf("rnd%0d_done_cycle", r), cyc, e_cyc);
      check($sformatf("rnd%0d_clf_en_count", r), en, e_en);
      check($sformatf("rnd%0d_clf_rst_count", r), nrst, e_nrst);
      check($sformatf("rnd%0d_trace_errors", r), errs, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
